dozen_dispatch: RTL
===================

// Module: dozen_dispatch
// PURPOSE
//  Shipping-side consumer of the dozen count. It loads a BCD order of N dozens
//  (00..99) and counts outgoing bottles down, 12 per dozen. It reports the
//  remaining dozens in BCD, pulses done when the order is fulfilled, and
//  returns to idle. Single-clock synchronous design; no derived/ripple clocks.
// PARAMETERS
//  DOZEN_SIZE   12    bottles per dozen (2..16); in-dozen counter runs DOZEN_SIZE-1 down to 0
//  WDOG_CYCLES  1000  idle RUN cycles before stall asserts (used only with DISPATCH_WDOG_EN)
//  WDOG_W       10    watchdog counter width; must satisfy 2**WDOG_W > WDOG_CYCLES
// PORTS
//  clk             in   1  system clock, rising edge
//  reset           in   1  asynchronous, active-low reset
//  load            in   1  start order; sampled only in IDLE
//  dezenas_in      in   4  order tens digit, BCD
//  unidades_in     in   4  order units digit, BCD
//  bottle          in   1  one bottle shipped this cycle (single-cycle strobe per bottle)
//  abort           in   1  cancel order in progress
//  dezenas_rest    out  4  remaining dozens, tens digit, BCD (includes the dozen in progress)
//  unidades_rest   out  4  remaining dozens, units digit, BCD
//  bottles_left    out  4  in-dozen down-counter, DOZEN_SIZE-1..0
//  busy            out  1  high while in RUN
//  done            out  1  one-cycle pulse: order fulfilled
//  load_err        out  1  one-cycle pulse: load rejected (non-BCD digit)
//  stall           out  1  watchdog flag (0 when feature is absent)
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE; all outputs 0; watchdog counter 0.
//  - All outputs are registered. States: IDLE, RUN, DONE.
//  - IDLE, load=1:
//    . Any digit > 9: load_err=1 next cycle, no other change.
//    . Order 00: done=1 next cycle (via DONE), busy stays 0.
//    . Otherwise: latch digits into *_rest, bottles_left=DOZEN_SIZE-1, go to RUN; busy=1 next cycle.
//  - bottle while in IDLE or DONE is ignored. load while in RUN or DONE is ignored.
//  - RUN, bottle=1, abort=0:
//    . bottles_left>0: bottles_left decrements.
//    . bottles_left==0 (dozen completed): bottles_left reloads to DOZEN_SIZE-1.
//      The BCD remaining count decrements: units 0 -> 9 with a borrow from tens,
//      otherwise units-1.
//    . If the remaining count was 01: go to DONE; *_rest=00, bottles_left=0, busy=0.
//  - DONE: done=1 for exactly one cycle, then IDLE. done is high in the cycle
//    after the clock edge that samples the final bottle.
//  - RUN, abort=1: next cycle is IDLE with *_rest=00, bottles_left=0, busy=0, and no done pulse.
//    If abort and bottle occur together, abort wins.
//  - Total bottles for order N = N*DOZEN_SIZE. The remaining count never wraps
//    below 00 and never leaves the BCD range.
//  - Reset asserted mid-RUN: immediate return to reset values; the order is lost.
// CONFIGURATION
//  DISPATCH_WDOG_EN defined:
//    . Watchdog counter increments each RUN cycle with bottle=0.
//    . It clears on bottle, abort, leaving RUN, or reset.
//    . When it reaches WDOG_CYCLES, stall=1. stall is sticky until the next
//      bottle, abort, or reset; it saturates and never wraps.
//    . stall does not alter the counting behaviour.
//  DISPATCH_WDOG_EN undefined: no watchdog logic; stall tied to 0.
// TESTING
//  1. Reset, then load dez=0 uni=1 with 12 bottle strobes
//     -> rest=01 and bottles_left 11..0 across strobes 1..11; the 12th strobe
//     gives done=1 for 1 cycle, rest=00, busy=0.
//  2. Load dez=1 uni=0 with 12 strobes -> unidades_rest=9, dezenas_rest=0,
//     bottles_left=11, busy=1.
//  3. Load dez=0xA uni=3 -> load_err=1 for 1 cycle, state IDLE, rest=00, busy=0.
//     Load 00 -> done=1 for 1 cycle, busy never asserts.
//  4. Load 05, send 30 strobes, then abort and bottle in the same cycle
//     -> next cycle rest=00, busy=0, no done; later strobes ignored.
//  5. Load 99, send 5 strobes, then assert reset=0 asynchronously mid-cycle
//     -> outputs 0 immediately without waiting for clk.
//  6. With DISPATCH_WDOG_EN and WDOG_CYCLES=8: load 02, hold bottle=0
//     -> stall=1 after 8 RUN cycles; one strobe gives stall=0 and bottles_left=10.

Source files
------------

// File: rtl/dozen_dispatch.sv
// Shipping-side dozen counter: loads a BCD order of dozens and counts bottles down to zero.
// Optional stall watchdog is compiled in with `define DISPATCH_WDOG_EN.
module dozen_dispatch #(
    parameter int unsigned DOZEN_SIZE  = 12,
    parameter int unsigned WDOG_CYCLES = 1000,
    parameter int unsigned WDOG_W      = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] dezenas_in,
    input  logic [3:0] unidades_in,
    input  logic       bottle,
    input  logic       abort,
    output logic [3:0] dezenas_rest,
    output logic [3:0] unidades_rest,
    output logic [3:0] bottles_left,
    output logic       busy,
    output logic       done,
    output logic       load_err,
    output logic       stall
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0] LEFT_MAX = 4'(DOZEN_SIZE - 1);

    if ((2 ** WDOG_W) <= WDOG_CYCLES || DOZEN_SIZE < 2 || DOZEN_SIZE > 16) begin : g_bad_params
        $error("dozen_dispatch: illegal parameter combination");
    end

    state_t     state_q, state_d;
    logic [3:0] dez_q, dez_d;
    logic [3:0] uni_q, uni_d;
    logic [3:0] left_q, left_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    always_comb begin
        state_d = state_q;
        dez_d   = dez_q;
        uni_d   = uni_q;
        left_d  = left_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    if (dezenas_in > 4'd9 || unidades_in > 4'd9) begin
                        err_d = 1'b1;
                    end else if (dezenas_in == 4'd0 && unidades_in == 4'd0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        dez_d   = dezenas_in;
                        uni_d   = unidades_in;
                        left_d  = LEFT_MAX;
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    dez_d   = '0;
                    uni_d   = '0;
                    left_d  = '0;
                    busy_d  = 1'b0;
                end else if (bottle) begin
                    if (left_q != 4'd0) begin
                        left_d = left_q - 4'd1;
                    end else if (dez_q == 4'd0 && uni_q == 4'd1) begin
                        state_d = DONE;
                        dez_d   = '0;
                        uni_d   = '0;
                        left_d  = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // dozen completed: BCD decrement with borrow from tens
                        left_d = LEFT_MAX;
                        if (uni_q == 4'd0) begin
                            uni_d = 4'd9;
                            dez_d = dez_q - 4'd1;
                        end else begin
                            uni_d = uni_q - 4'd1;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            dez_q   <= '0;
            uni_q   <= '0;
            left_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dez_q   <= dez_d;
            uni_q   <= uni_d;
            left_q  <= left_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign dezenas_rest  = dez_q;
    assign unidades_rest = uni_q;
    assign bottles_left  = left_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign load_err      = err_q;

`ifdef DISPATCH_WDOG_EN
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_ONE   = WDOG_W'(1);

    logic [WDOG_W-1:0] wcnt_q, wcnt_d;
    logic              stall_q, stall_d;

    // Counting only happens in RUN without bottle/abort; any other cycle clears both.
    always_comb begin
        wcnt_d  = '0;
        stall_d = 1'b0;
        if (state_q == RUN && !bottle && !abort) begin
            wcnt_d  = (wcnt_q == WDOG_LIMIT) ? wcnt_q : wcnt_q + WDOG_ONE;
            stall_d = stall_q | (wcnt_d == WDOG_LIMIT);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt_q  <= '0;
            stall_q <= 1'b0;
        end else begin
            wcnt_q  <= wcnt_d;
            stall_q <= stall_d;
        end
    end

    assign stall = stall_q;
`else
    assign stall = 1'b0;
`endif

endmodule
